decode_onehot_seq: RTL and testbench
====================================

// Module: decode_onehot_seq
// PURPOSE
//   Registered, parametrised binary-to-one-hot decoder for register-file and bus-source selects.
//   Successor to the fixed 4-to-16 select decoder. Adds:
//     - selectable output count
//     - explicit valid and out-of-range error flags
//     - a SCAN mode that walks the one-hot output across indices 0..scan_last under an ack
//       handshake, for register clear/dump sequences driven by the control unit.
// PARAMETERS
//   SEL_W    4    width of sel and scan_last
//   NUM_OUT  16   number of one-hot outputs; legal range 2..2**SEL_W
// PORTS
//   clk        in   1        rising-edge clock
//   clear_n    in   1        asynchronous active-low reset
//   en         in   1        request a single decode of sel (IDLE only)
//   sel        in   SEL_W    index to decode
//   start_scan in   1        request a scan 0..scan_last (IDLE only)
//   scan_last  in   SEL_W    last scan index; sampled at scan start
//   ack        in   1        consumer accepted current scan output
//   d_out      out  NUM_OUT  registered one-hot select
//   valid      out  1        d_out is valid this cycle
//   busy       out  1        SCAN in progress
//   done       out  1        one-cycle pulse after final scan ack
//   err        out  1        one-cycle pulse: single decode with sel >= NUM_OUT
//   cur_idx    out  SEL_W    index currently driven on d_out
// BEHAVIOUR
//   Reset (clear_n=0, asynchronous): d_out=0, valid=0, busy=0, done=0, err=0, cur_idx=0, state=IDLE.
//     Takes effect immediately, including mid-scan. No done pulse is issued for an aborted scan.
//   States: IDLE, SCAN, FIN. All outputs are registered.
//   IDLE, en=1 and start_scan=0:
//     - Next edge: d_out=1<<sel, cur_idx=sel, valid=1 for exactly one cycle. Latency = 1 clock.
//     - d_out then holds its value until the next update. valid returns to 0.
//     - If sel >= NUM_OUT: d_out=0, valid=0, err=1 for one cycle, cur_idx=sel.
//   IDLE, start_scan=1 (takes priority over en in the same cycle):
//     - Latch last = min(scan_last, NUM_OUT-1).
//     - Next edge: state=SCAN, busy=1, cur_idx=0, d_out=1, valid=1.
//   SCAN:
//     - valid stays 1 and d_out is stable until ack=1 is seen on a rising edge.
//     - On ack with cur_idx<last: cur_idx+1, d_out shifts left by 1. Exactly one bit stays set.
//     - On ack with cur_idx==last: state=FIN, d_out=0, valid=0, busy=0, done=1.
//     - en and start_scan are ignored in SCAN and FIN. cur_idx never wraps past last.
//     - ack asserted while valid=0 has no effect.
//   FIN: done stays high for one cycle, then state=IDLE. cur_idx keeps its final value.
//   Zero-length scan (last==0): one output (d_out=1) is presented; the first ack ends the scan.
//   Invariant: popcount(d_out) <= 1 at every cycle.
//   Width rules: d_out is computed as an NUM_OUT-bit shift, not truncated from a wider constant.
//     NUM_OUT=2**SEL_W makes err unreachable.
// TESTING
//   1) Reset, en=1, sel=5
//      -> one cycle later d_out=16'h0020, valid=1 for 1 cycle; d_out then holds 16'h0020.
//   2) NUM_OUT=12, en=1, sel=13
//      -> d_out=0, err=1 for 1 cycle, valid=0.
//   3) start_scan=1, scan_last=3, ack held high
//      -> d_out goes 0001, 0002, 0004, 0008 on consecutive cycles, then done=1 and busy=0.
//   4) Scan with ack low for 3 cycles on idx 2
//      -> d_out=16'h0004 held 4 cycles, then advances; en pulses during the scan are ignored.
//   5) start_scan=1 and en=1 in the same cycle with sel=9
//      -> scan starts at d_out=1; 16'h0200 never appears.
//   6) clear_n=0 asynchronously at scan idx 6
//      -> all outputs 0 immediately, no done; after release, a new decode of sel=15 gives 16'h8000.

Source files
------------

// File: rtl/decode_onehot_seq.sv
// Registered binary-to-one-hot decoder with out-of-range error flag and an
// ack-paced scan mode that walks the one-hot output across indices 0..last.
module decode_onehot_seq #(
   parameter int SEL_W   = 4,
   parameter int NUM_OUT = 16
) (
   input  logic               clk,
   input  logic               clear_n,
   input  logic               en,
   input  logic [SEL_W-1:0]   sel,
   input  logic               start_scan,
   input  logic [SEL_W-1:0]   scan_last,
   input  logic               ack,
   output logic [NUM_OUT-1:0] d_out,
   output logic               valid,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [SEL_W-1:0]   cur_idx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   localparam logic [NUM_OUT-1:0] ONE_HOT_0 = NUM_OUT'(1);
   localparam logic [SEL_W-1:0]   MAX_IDX   = SEL_W'(NUM_OUT - 1);

   state_t               state_q,   state_d;
   logic [NUM_OUT-1:0]   d_out_q,   d_out_d;
   logic                 valid_q,   valid_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
   logic                 err_q,     err_d;
   logic [SEL_W-1:0]     cur_idx_q, cur_idx_d;
   logic [SEL_W-1:0]     last_q,    last_d;

   logic                 sel_in_range;
   logic [SEL_W-1:0]     scan_last_clamped;
   logic                 at_last;

   // Compare in 32 bits so NUM_OUT == 2**SEL_W does not wrap the bound.
   assign sel_in_range      = (32'(sel) < 32'(NUM_OUT));
   assign scan_last_clamped = (32'(scan_last) > 32'(NUM_OUT - 1)) ? MAX_IDX : scan_last;
   assign at_last           = (cur_idx_q == last_q);

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d   = state_q;
      d_out_d   = d_out_q;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cur_idx_d = cur_idx_q;
      last_d    = last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_scan) begin
               last_d    = scan_last_clamped;
               state_d   = ST_SCAN;
               busy_d    = 1'b1;
               cur_idx_d = '0;
               d_out_d   = ONE_HOT_0;
               valid_d   = 1'b1;
            end else if (en) begin
               cur_idx_d = sel;
               if (sel_in_range) begin
                  d_out_d = ONE_HOT_0 << sel;
                  valid_d = 1'b1;
               end else begin
                  d_out_d = '0;
                  err_d   = 1'b1;
               end
            end
         end

         ST_SCAN: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            if (ack) begin
               if (at_last) begin
                  state_d = ST_FIN;
                  d_out_d = '0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cur_idx_d = cur_idx_q + SEL_W'(1);
                  d_out_d   = d_out_q << 1;
               end
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            d_out_d = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= ST_IDLE;
         d_out_q   <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cur_idx_q <= '0;
         last_q    <= '0;
      end else begin
         state_q   <= state_d;
         d_out_q   <= d_out_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cur_idx_q <= cur_idx_d;
         last_q    <= last_d;
      end
   end

   assign d_out   = d_out_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_decode_onehot_seq.sv
// Directed bench for decode_onehot_seq: a 16-output and a 12-output instance,
// expectations queued as stimulus is driven and compared after each edge.
module tb_decode_onehot_seq;

   logic        clk = 1'b0;
   logic        clear_n;

   logic        en, start_scan, ack;
   logic [3:0]  sel, scan_last;
   logic [15:0] d_out;
   logic        valid, busy, done, err;
   logic [3:0]  cur_idx;

   logic        en12, start12, ack12;
   logic [3:0]  sel12, last12;
   logic [11:0] d12;
   logic        valid12, busy12, done12, err12;
   logic [3:0]  idx12;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int          unit;
      string       tag;
      logic [23:0] vec;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   decode_onehot_seq #(.SEL_W(4), .NUM_OUT(16)) dut (
      .clk(clk), .clear_n(clear_n), .en(en), .sel(sel),
      .start_scan(start_scan), .scan_last(scan_last), .ack(ack),
      .d_out(d_out), .valid(valid), .busy(busy), .done(done),
      .err(err), .cur_idx(cur_idx)
   );

   decode_onehot_seq #(.SEL_W(4), .NUM_OUT(12)) dut12 (
      .clk(clk), .clear_n(clear_n), .en(en12), .sel(sel12),
      .start_scan(start12), .scan_last(last12), .ack(ack12),
      .d_out(d12), .valid(valid12), .busy(busy12), .done(done12),
      .err(err12), .cur_idx(idx12)
   );

   function automatic logic [23:0] observe(input int unit);
      if (unit == 0) return {d_out, valid, busy, done, err, cur_idx};
      else           return {4'h0, d12, valid12, busy12, done12, err12, idx12};
   endfunction

   task automatic expect_out(input int unit, input string tag, input logic [15:0] d,
                             input logic v, input logic b, input logic dn,
                             input logic e, input logic [3:0] idx);
      exp_t x;
      x.unit = unit;
      x.tag  = tag;
      x.vec  = {d, v, b, dn, e, idx};
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      logic [23:0] obs;
      while (sb.size() > 0) begin
         x   = sb.pop_front();
         obs = observe(x.unit);
         n_total++;
         assert (obs === x.vec) n_pass++;
         else $error("FAIL %s: observed d_out=%h v/b/d/e=%b idx=%0d, expected d_out=%h v/b/d/e=%b idx=%0d",
                     x.tag, obs[23:8], obs[7:4], obs[3:0], x.vec[23:8], x.vec[7:4], x.vec[3:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   // One-hot invariant on both instances, checked between edges.
   always @(negedge clk) begin
      if (clear_n === 1'b1) begin
         n_total += 2;
         assert ($countones(d_out) <= 1) n_pass++;
         else $error("FAIL onehot16: observed d_out=%h, expected at most one bit set", d_out);
         assert ($countones(d12) <= 1) n_pass++;
         else $error("FAIL onehot12: observed d_out=%h, expected at most one bit set", d12);
      end
   end

   initial begin
      clear_n = 1'b0;
      en = 0; start_scan = 0; ack = 0; sel = '0; scan_last = '0;
      en12 = 0; start12 = 0; ack12 = 0; sel12 = '0; last12 = '0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      expect_out(0, "reset16", 16'h0, 0, 0, 0, 0, 4'd0);
      expect_out(1, "reset12", 16'h0, 0, 0, 0, 0, 4'd0);
      drain();
      clear_n = 1'b1;

      // Single decode sel=5, then hold with valid low
      en = 1; sel = 4'd5;
      expect_out(0, "dec5", 16'h0020, 1, 0, 0, 0, 4'd5);
      tick();
      en = 0;
      expect_out(0, "dec5_hold1", 16'h0020, 0, 0, 0, 0, 4'd5);
      tick();
      expect_out(0, "dec5_hold2", 16'h0020, 0, 0, 0, 0, 4'd5);
      tick();

      // NUM_OUT=12: out of range, top legal index, first illegal index
      en12 = 1; sel12 = 4'd13;
      expect_out(1, "err13", 16'h0, 0, 0, 0, 1, 4'd13);
      tick();
      sel12 = 4'd11;
      expect_out(1, "dec11", 16'h0800, 1, 0, 0, 0, 4'd11);
      tick();
      sel12 = 4'd12;
      expect_out(1, "err12", 16'h0, 0, 0, 0, 1, 4'd12);
      tick();
      en12 = 0;
      expect_out(1, "err_clear", 16'h0, 0, 0, 0, 0, 4'd12);
      tick();

      // Scan 0..3 with ack held high
      start_scan = 1; scan_last = 4'd3; ack = 1;
      expect_out(0, "scan3_i0", 16'h0001, 1, 1, 0, 0, 4'd0);
      tick();
      start_scan = 0;
      for (int i = 1; i <= 3; i++) begin
         expect_out(0, $sformatf("scan3_i%0d", i), 16'(1 << i), 1, 1, 0, 0, 4'(i));
         tick();
      end
      expect_out(0, "scan3_done", 16'h0, 0, 0, 1, 0, 4'd3);
      tick();
      ack = 0;
      expect_out(0, "scan3_idle", 16'h0, 0, 0, 0, 0, 4'd3);
      tick();

      // Scan 0..4 with ack withheld at idx 2 while en pulses
      start_scan = 1; scan_last = 4'd4;
      expect_out(0, "stall_i0", 16'h0001, 1, 1, 0, 0, 4'd0);
      tick();
      start_scan = 0; ack = 1;
      expect_out(0, "stall_i1", 16'h0002, 1, 1, 0, 0, 4'd1);
      tick();
      expect_out(0, "stall_i2", 16'h0004, 1, 1, 0, 0, 4'd2);
      tick();
      ack = 0; en = 1; sel = 4'd9;
      for (int i = 0; i < 3; i++) begin
         expect_out(0, $sformatf("stall_hold%0d", i), 16'h0004, 1, 1, 0, 0, 4'd2);
         tick();
      end
      en = 0; ack = 1;
      expect_out(0, "stall_i3", 16'h0008, 1, 1, 0, 0, 4'd3);
      tick();
      expect_out(0, "stall_i4", 16'h0010, 1, 1, 0, 0, 4'd4);
      tick();
      expect_out(0, "stall_done", 16'h0, 0, 0, 1, 0, 4'd4);
      tick();
      ack = 0;
      expect_out(0, "stall_idle", 16'h0, 0, 0, 0, 0, 4'd4);
      tick();

      // start_scan and en together, zero-length scan
      start_scan = 1; en = 1; sel = 4'd9; scan_last = 4'd0;
      expect_out(0, "prio_i0", 16'h0001, 1, 1, 0, 0, 4'd0);
      tick();
      start_scan = 0; en = 0;
      expect_out(0, "zero_hold", 16'h0001, 1, 1, 0, 0, 4'd0);
      tick();
      ack = 1;
      expect_out(0, "zero_done", 16'h0, 0, 0, 1, 0, 4'd0);
      tick();
      ack = 0;
      expect_out(0, "zero_idle", 16'h0, 0, 0, 0, 0, 4'd0);
      tick();

      // NUM_OUT=12 scan with scan_last beyond range clamps to 11
      start12 = 1; last12 = 4'd15; ack12 = 1;
      for (int i = 0; i <= 11; i++) begin
         expect_out(1, $sformatf("clamp_i%0d", i), 16'(1 << i), 1, 1, 0, 0, 4'(i));
         tick();
         start12 = 0;
      end
      expect_out(1, "clamp_done", 16'h0, 0, 0, 1, 0, 4'd11);
      tick();
      ack12 = 0;
      expect_out(1, "clamp_idle", 16'h0, 0, 0, 0, 0, 4'd11);
      tick();

      // Asynchronous reset at scan idx 6
      start_scan = 1; scan_last = 4'd10; ack = 1;
      expect_out(0, "abort_i0", 16'h0001, 1, 1, 0, 0, 4'd0);
      tick();
      start_scan = 0;
      for (int i = 1; i <= 6; i++) begin
         expect_out(0, $sformatf("abort_i%0d", i), 16'(1 << i), 1, 1, 0, 0, 4'(i));
         tick();
      end
      #2;
      clear_n = 1'b0;
      #1;
      expect_out(0, "abort_now", 16'h0, 0, 0, 0, 0, 4'd0);
      drain();
      expect_out(0, "abort_nodone", 16'h0, 0, 0, 0, 0, 4'd0);
      tick();
      clear_n = 1'b1; ack = 0; en = 1; sel = 4'd15;
      expect_out(0, "dec15", 16'h8000, 1, 0, 0, 0, 4'd15);
      tick();
      en = 0;
      expect_out(0, "dec15_hold", 16'h8000, 0, 0, 0, 0, 4'd15);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
